alu_issue_stage: RTL

//  Operand/control issue stage directly upstream of main_ALU in the multi-cycle datapath.
//  - Accepts one decoded instruction (opcode, funct, shamt, imm16, rs/rt data) per valid/ready handshake.
//  - Drives srca/srcb/ALUControl into main_ALU and waits out its registered output.
//  - Returns result and zero flag to the control FSM on a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 89 ++++++++
 rtl/alu_decode.sv | 83 ++++++++
 rtl/alu_issue_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, opcode/funct
// values, FSM states, operand-select and immediate-extend codes.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned IMM_W_DEF  = 16;
  localparam int unsigned CTRL_W     = 4;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned SHAMT_W    = 5;

  // ALUControl codes understood by main_ALU
  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_MUL = 4'b0010,
    ALU_DIV = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_AND = 4'b0101,
    ALU_OR  = 4'b0110,
    ALU_NOT = 4'b0111,
    ALU_NOR = 4'b1000,
    ALU_SLT = 4'b1001,
    ALU_SLL = 4'b1010,
    ALU_SRL = 4'b1011,
    ALU_SRA = 4'b1100
  } alu_ctrl_e;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [OP_W-1:0] FN_SLL = 6'h00;
  localparam logic [OP_W-1:0] FN_SRL = 6'h02;
  localparam logic [OP_W-1:0] FN_SRA = 6'h03;
  localparam logic [OP_W-1:0] FN_MUL = 6'h18;
  localparam logic [OP_W-1:0] FN_DIV = 6'h1A;
  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR = 6'h26;
  localparam logic [OP_W-1:0] FN_NOR = 6'h27;
  localparam logic [OP_W-1:0] FN_NOT = 6'h28;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  // Issue FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  typedef enum logic {
    SRCA_RS = 1'b0,
    SRCA_RT = 1'b1
  } srca_sel_e;

  typedef enum logic [1:0] {
    SRCB_RT    = 2'd0,
    SRCB_SHAMT = 2'd1,
    SRCB_IMM   = 2'd2
  } srcb_sel_e;

  typedef enum logic {
    EXT_SIGN = 1'b0,
    EXT_ZERO = 1'b1
  } ext_mode_e;

  // Decoded control bundle handed from alu_decode to the issue stage
  typedef struct packed {
    alu_ctrl_e ctrl;
    srca_sel_e srca_sel;
    srcb_sel_e srcb_sel;
    ext_mode_e ext_mode;
    logic      illegal;
  } decode_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decode: opcode/funct -> ALU control, operand
// selects, immediate extend mode and illegal flag.
// Optional feature: DIV_ZERO_TRAP_EN makes div with rt_data==0 illegal.
module alu_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
`ifdef DIV_ZERO_TRAP_EN
  input  logic            rt_is_zero,
`endif
  output decode_t         dec_c
);

  // Decode table; anything not listed is illegal
  always_comb begin
    dec_c = '{ctrl: ALU_ADD, srca_sel: SRCA_RS, srcb_sel: SRCB_RT,
              ext_mode: EXT_SIGN, illegal: 1'b0};
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: dec_c.ctrl = ALU_ADD;
          FN_SUB: dec_c.ctrl = ALU_SUB;
          FN_MUL: dec_c.ctrl = ALU_MUL;
          FN_DIV: begin
            dec_c.ctrl = ALU_DIV;
`ifdef DIV_ZERO_TRAP_EN
            dec_c.illegal = rt_is_zero;
`endif
          end
          FN_XOR: dec_c.ctrl = ALU_XOR;
          FN_AND: dec_c.ctrl = ALU_AND;
          FN_OR:  dec_c.ctrl = ALU_OR;
          FN_NOT: dec_c.ctrl = ALU_NOT;
          FN_NOR: dec_c.ctrl = ALU_NOR;
          FN_SLT: dec_c.ctrl = ALU_SLT;
          FN_SLL: begin
            dec_c.ctrl     = ALU_SLL;
            dec_c.srca_sel = SRCA_RT;
            dec_c.srcb_sel = SRCB_SHAMT;
          end
          FN_SRL: begin
            dec_c.ctrl     = ALU_SRL;
            dec_c.srca_sel = SRCA_RT;
            dec_c.srcb_sel = SRCB_SHAMT;
          end
          FN_SRA: begin
            dec_c.ctrl     = ALU_SRA;
            dec_c.srca_sel = SRCA_RT;
            dec_c.srcb_sel = SRCB_SHAMT;
          end
          default: dec_c.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        dec_c.ctrl     = ALU_ADD;
        dec_c.srcb_sel = SRCB_IMM;
      end
      OP_SLTI: begin
        dec_c.ctrl     = ALU_SLT;
        dec_c.srcb_sel = SRCB_IMM;
      end
      OP_ANDI: begin
        dec_c.ctrl     = ALU_AND;
        dec_c.srcb_sel = SRCB_IMM;
        dec_c.ext_mode = EXT_ZERO;
      end
      OP_ORI: begin
        dec_c.ctrl     = ALU_OR;
        dec_c.srcb_sel = SRCB_IMM;
        dec_c.ext_mode = EXT_ZERO;
      end
      OP_XORI: begin
        dec_c.ctrl     = ALU_XOR;
        dec_c.srcb_sel = SRCB_IMM;
        dec_c.ext_mode = EXT_ZERO;
      end
      OP_BEQ, OP_BNE: dec_c.ctrl = ALU_SUB;
      default: dec_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand/control issue stage in front of main_ALU: accepts one decoded
// instruction, drives the ALU, waits out its registered output and returns
// the captured result over a valid/ready handshake.
// Optional feature: DIV_ZERO_TRAP_EN traps div-by-zero as illegal.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMM_W  = IMM_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [IMM_W-1:0]   imm16,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  output logic [DATA_W-1:0]  srca,
  output logic [DATA_W-1:0]  srcb,
  output logic [CTRL_W-1:0]  alu_control,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_zero,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic               res_zero,
  output logic               res_illegal
);

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_W-1:0]   srca_q, srca_d;
  logic [DATA_W-1:0]   srcb_q, srcb_d;
  alu_ctrl_e           ctrl_q, ctrl_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_zero_q, res_zero_d;
  logic                res_illegal_q, res_illegal_d;

  decode_t             dec_c;
  logic [DATA_W-1:0]   imm_ext_c;
  logic [DATA_W-1:0]   srca_iss_c;
  logic [DATA_W-1:0]   srcb_iss_c;

`ifdef DIV_ZERO_TRAP_EN
  logic rt_is_zero_c;
  assign rt_is_zero_c = (rt_data == '0);
`endif

  alu_decode u_decode (
    .opcode     (opcode),
    .funct      (funct),
`ifdef DIV_ZERO_TRAP_EN
    .rt_is_zero (rt_is_zero_c),
`endif
    .dec_c      (dec_c)
  );

  // Operand selection for the instruction being offered
  always_comb begin
    if (dec_c.ext_mode == EXT_ZERO) begin
      imm_ext_c = {{(DATA_W-IMM_W){1'b0}}, imm16};
    end else begin
      imm_ext_c = {{(DATA_W-IMM_W){imm16[IMM_W-1]}}, imm16};
    end
    srca_iss_c = (dec_c.srca_sel == SRCA_RT) ? rt_data : rs_data;
    case (dec_c.srcb_sel)
      SRCB_SHAMT: srcb_iss_c = {{(DATA_W-SHAMT_W){1'b0}}, shamt};
      SRCB_IMM:   srcb_iss_c = imm_ext_c;
      default:    srcb_iss_c = rt_data;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    srca_d        = srca_q;
    srcb_d        = srcb_q;
    ctrl_d        = ctrl_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_zero_d    = res_zero_q;
    res_illegal_d = res_illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          srca_d     = srca_iss_c;
          srcb_d     = srcb_iss_c;
          ctrl_d     = dec_c.ctrl;
          in_ready_d = 1'b0;
          if (dec_c.illegal) begin
            state_d       = ST_RESP;
            res_valid_d   = 1'b1;
            res_illegal_d = 1'b1;
            res_data_d    = '0;
            res_zero_d    = 1'b0;
          end else begin
            state_d       = ST_ISSUE;
            res_illegal_d = 1'b0;
          end
        end
      end
      ST_ISSUE: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d     = ST_RESP;
        res_data_d  = alu_out;
        res_zero_d  = alu_zero;
        res_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      in_ready_q    <= 1'b1;
      srca_q        <= '0;
      srcb_q        <= '0;
      ctrl_q        <= ALU_ADD;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_zero_q    <= 1'b0;
      res_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      srca_q        <= srca_d;
      srcb_q        <= srcb_d;
      ctrl_q        <= ctrl_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_zero_q    <= res_zero_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign srca        = srca_q;
  assign srcb        = srcb_q;
  assign alu_control = ctrl_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_zero    = res_zero_q;
  assign res_illegal = res_illegal_q;

endmodule
